ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter. Sends command bytes to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) on the
//  PS2_CLK/PS2_DAT lines shared with ps2_kbd_adapter. Open-drain: outputs only pull low. Runs in CLOCK_50 domain.
//  tx_busy lets the top gate make_pulse while a command is on the wire.
// PARAMETERS
//  CLK_HZ        50_000_000  system clock frequency; all timers derive from it
//  INHIBIT_US    120         PS2_CLK hold-low time before request-to-send
//  START_TO_US   15000       max wait for first device falling edge after clock release
//  PKT_TO_US     2000        max time from first device falling edge to ack edge
//  RETRIES       2           extra attempts after an error (only with PS2_TX_RETRY_EN)
// PORTS
//  clk          in   1  system clock (CLOCK_50)
//  reset_n      in   1  asynchronous, active-low reset
//  tx_data      in   8  command byte; captured when tx_valid && tx_ready
//  tx_valid     in   1  request to send
//  tx_ready     out  1  high only in IDLE
//  tx_busy      out  1  high in every state except IDLE
//  tx_done      out  1  one-cycle pulse: byte acknowledged by device, lines idle
//  tx_err       out  1  one-cycle pulse: transfer abandoned
//  err_code     out  2  valid with tx_err: 01 start timeout, 10 packet timeout, 11 no ack
//  ps2_clk_in   in   1  raw PS2_CLK pin level
//  ps2_dat_in   in   1  raw PS2_DAT pin level
//  ps2_clk_oe   out  1  1 = drive PS2_CLK low, 0 = release (top: PS2_CLK = oe ? 1'b0 : 1'bz)
//  ps2_dat_oe   out  1  1 = drive PS2_DAT low, 0 = release
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE; ps2_clk_oe=0, ps2_dat_oe=0, tx_done=0, tx_err=0, err_code=0,
//    tx_busy=0, tx_ready=1. Reset mid-transfer releases both lines immediately; no done/err pulse.
//  - ps2_clk_in/ps2_dat_in pass through 2-FF synchronisers; falling edge = prev synced 1, now 0 (3rd FF).
//  - Frame shift reg {stop=1, parity, D7..D0} built at accept; parity = ~^tx_data (odd parity).
//  - IDLE: tx_valid && tx_ready -> capture byte, bit_cnt=0, go INHIBIT. tx_valid while busy is ignored.
//  - INHIBIT: clk_oe=1 for INHIBIT_US*CLK_HZ/1e6 cycles (6000 at default); any device frame in flight is aborted.
//    Last cycle: dat_oe=1 (start bit 0), next cycle clk_oe=0 -> WAIT_DEV.
//  - WAIT_DEV: dat_oe held 1. First falling edge -> drive D0 (dat_oe = ~D0), bit_cnt=1, start packet timer,
//    go SHIFT. No edge within START_TO_US -> tx_err, err_code=01, release lines, IDLE.
//  - SHIFT: each falling edge drives next frame bit (dat_oe = ~bit), bit_cnt++. Edges 1..8 = D0..D7, 9 = parity,
//    10 = stop (dat_oe=0, line released). After edge 10 -> ACK.
//  - ACK: on edge 11 sample synced ps2_dat: 0 -> WAIT_IDLE; 1 -> tx_err, err_code=11, IDLE.
//  - WAIT_IDLE: wait until synced clk=1 and dat=1 simultaneously -> tx_done pulse, IDLE.
//  - Packet timer runs from edge 1 through WAIT_IDLE; expiry (PKT_TO_US) in any of SHIFT/ACK/WAIT_IDLE ->
//    tx_err, err_code=10, both oe=0, IDLE. Timer expiry and an edge in the same cycle: timeout wins.
//  - tx_done and tx_err never assert together; err_code holds its value until the next tx_err.
//  - Timers are saturating counters sized $clog2 of max cycle count; no wrap.
//  - Device responses (0xFA ack byte, 0xFE resend) are received by ps2_kbd_adapter, not interpreted here.
// CONFIGURATION
//  PS2_TX_RETRY_EN defined: on any error the same byte is resent from INHIBIT, up to RETRIES extra attempts;
//    tx_err/err_code pulse only after the final failed attempt; tx_busy stays high across retries;
//    attempt counter cleared on accept.
//  PS2_TX_RETRY_EN undefined: first error ends the transfer; RETRIES unused.
// TESTING  (bench overrides CLK_HZ=1_000_000; device model clocks at 12.5 kHz = 80 cycles)
//  1 tx_data=0xED, model clocks 11 edges, acks low -> wire bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done once.
//  2 tx_data=0x07 -> parity bit 0; tx_data=0xFF -> parity bit 1; both tx_done, no tx_err.
//  3 model never clocks -> clk_oe low 120 cycles, then tx_err with err_code=01 at 15000 cycles; lines released.
//  4 model holds dat high on edge 11 -> tx_err, err_code=11 (retry off); with PS2_TX_RETRY_EN: 3 attempts then err.
//  5 model stops after edge 5 -> tx_err, err_code=10 at 2000 cycles after edge 1; oe both 0.
//  6 reset_n low during SHIFT -> clk_oe=dat_oe=0 same cycle, tx_ready=1, no pulse; new 0xF4 then completes.

Source files
------------

// File: rtl/ps2_host_tx.sv
//-----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs,
// 0xFF reset) to the keyboard over the open-drain PS2_CLK/PS2_DAT lines. These
// lines are shared with the receive-side adapter. The outputs only ever pull a
// line low. All logic runs in the system clock domain.
//
// Optional feature macro: PS2_TX_RETRY_EN
//   When defined, a failed attempt resends the same byte from INHIBIT, up to
//   RETRIES extra times. tx_err is raised only after the last failed attempt.
//   When undefined, the first error ends the transfer.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   tx_data/tx_valid      command byte, captured when tx_valid && tx_ready
//   tx_ready              high only while idle
//   tx_busy               high whenever a command is in progress
//   tx_done               1-cycle pulse: byte acknowledged, lines idle again
//   tx_err/err_code       1-cycle pulse plus reason code
//                         (01 start timeout, 10 packet timeout, 11 no ack)
//                         err_code holds its value until the next error.
//   ps2_clk_in/dat_in     raw pin levels (asynchronous)
//   ps2_clk_oe/dat_oe     1 = pull the line low, 0 = release it
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int INHIBIT_US  = 120,
  parameter int START_TO_US = 15000,
  parameter int PKT_TO_US   = 2000,
  parameter int RETRIES     = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  // Microsecond figures are converted to cycles in 64-bit arithmetic, because
  // us * Hz overflows 32 bits at 50 MHz.
  localparam int INH_CYC   = int'(longint'(INHIBIT_US)  * longint'(CLK_HZ) / 64'sd1_000_000);
  localparam int START_CYC = int'(longint'(START_TO_US) * longint'(CLK_HZ) / 64'sd1_000_000);
  localparam int PKT_CYC   = int'(longint'(PKT_TO_US)   * longint'(CLK_HZ) / 64'sd1_000_000);
  localparam int MAX_CYC   = (START_CYC > PKT_CYC) ?
                             ((START_CYC > INH_CYC) ? START_CYC : INH_CYC) :
                             ((PKT_CYC > INH_CYC) ? PKT_CYC : INH_CYC);
  localparam int TMR_W     = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] TMR_SAT    = '1;
  localparam logic [TMR_W-1:0] INH_DAT    = TMR_W'(INH_CYC - 2);
  localparam logic [TMR_W-1:0] INH_LAST   = TMR_W'(INH_CYC - 1);
  localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_CYC - 1);
  localparam logic [TMR_W-1:0] PKT_LAST   = TMR_W'(PKT_CYC - 1);

`ifdef PS2_TX_RETRY_EN
  localparam int RETRY_LIMIT = RETRIES;
`else
  // Retry disabled: no extra attempts after an error.
  localparam int RETRY_LIMIT = 0 * RETRIES;
`endif
  localparam int ATT_W = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_WAIT_DEV, S_SHIFT, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [ATT_W-1:0]   attempt_q, attempt_d;
  logic               clk_oe_q, clk_oe_d;
  logic               dat_oe_q, dat_oe_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [2:0]         clk_sync_q, clk_sync_d;
  logic [1:0]         dat_sync_q, dat_sync_d;
  // Frame bits still to go out, LSB first: {stop, parity, D7..D0}.
  logic [9:0]         frame_q, frame_d;
  logic [7:0]         data_q, data_d;

  logic               clk_s, dat_s, clk_fall;
  logic               fail;
  logic [1:0]         fail_code;

  assign clk_s    = clk_sync_q[1];
  assign dat_s    = dat_sync_q[1];
  assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];

  always_comb begin
    state_d    = state_q;
    timer_d    = (timer_q == TMR_SAT) ? timer_q : timer_q + TMR_W'(1);
    bit_cnt_d  = bit_cnt_q;
    attempt_d  = attempt_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    clk_sync_d = {clk_sync_q[1:0], ps2_clk_in};
    dat_sync_d = {dat_sync_q[0], ps2_dat_in};
    frame_d    = frame_q;
    data_d     = data_q;
    fail       = 1'b0;
    fail_code  = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          data_d    = tx_data;
          frame_d   = {1'b1, ~^tx_data, tx_data};
          bit_cnt_d = 4'd0;
          attempt_d = '0;
          timer_d   = '0;
          clk_oe_d  = 1'b1;
          dat_oe_d  = 1'b0;
          state_d   = S_INHIBIT;
        end
      end
      // Clock held low; the start bit goes onto DAT in the last inhibit cycle,
      // so it is already low when CLK is released.
      S_INHIBIT: begin
        if (timer_q == INH_DAT) dat_oe_d = 1'b1;
        if (timer_q == INH_LAST) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          timer_d  = '0;
          state_d  = S_WAIT_DEV;
        end
      end
      S_WAIT_DEV: begin
        if (timer_q == START_LAST) begin
          fail      = 1'b1;
          fail_code = 2'b01;
        end else if (clk_fall) begin
          dat_oe_d  = ~frame_q[0];
          frame_d   = {1'b1, frame_q[9:1]};
          bit_cnt_d = 4'd1;
          timer_d   = '0;
          state_d   = S_SHIFT;
        end
      end
      // Edges 2..10 put out D1..D7, parity and stop. The stop bit is 1, so the
      // line is released on edge 10.
      S_SHIFT: begin
        if (timer_q == PKT_LAST) begin
          fail      = 1'b1;
          fail_code = 2'b10;
        end else if (clk_fall) begin
          dat_oe_d  = ~frame_q[0];
          frame_d   = {1'b1, frame_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (timer_q == PKT_LAST) begin
          fail      = 1'b1;
          fail_code = 2'b10;
        end else if (clk_fall) begin
          if (!dat_s) begin
            state_d = S_WAIT_IDLE;
          end else begin
            fail      = 1'b1;
            fail_code = 2'b11;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (timer_q == PKT_LAST) begin
          fail      = 1'b1;
          fail_code = 2'b10;
        end else if (clk_s && dat_s) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every error path releases both lines. The byte is then either retried
    // from INHIBIT or the transfer is abandoned.
    if (fail) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      if (int'(attempt_q) < RETRY_LIMIT) begin
        attempt_d = attempt_q + ATT_W'(1);
        frame_d   = {1'b1, ~^data_q, data_q};
        bit_cnt_d = 4'd0;
        timer_d   = '0;
        clk_oe_d  = 1'b1;
        state_d   = S_INHIBIT;
      end else begin
        err_d      = 1'b1;
        err_code_d = fail_code;
        state_d    = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= 4'd0;
      attempt_q  <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      attempt_q  <= attempt_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
    end
  end

  always_ff @(posedge clk) begin
    frame_q <= frame_d;
    data_q  <= data_d;
  end

  assign tx_ready   = (state_q == S_IDLE);
  assign tx_busy    = (state_q != S_IDLE);
  assign tx_done    = done_q;
  assign tx_err     = err_q;
  assign err_code   = err_code_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule
